// File: rtl/int_rf_wb_arbiter.sv
// Round-robin write-back arbiter for the integer register file's single write port,
// plus a 32-entry busy scoreboard that issue logic uses for RAW/WAW hazard checks.
module int_rf_wb_arbiter #(
  parameter int XLEN = 64,
  parameter int NREQ = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [5*NREQ-1:0]      req_addr,
  input  logic [XLEN*NREQ-1:0]   req_data,
  output logic                   wen_out,
  output logic [4:0]             waddr_out,
  output logic [XLEN-1:0]        wdata_out,
  input  logic                   iss_valid,
  input  logic [4:0]             iss_rd,
  input  logic [4:0]             iss_rs1,
  input  logic [4:0]             iss_rs2,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  output logic                   rd_busy,
  output logic                   sb_fault
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             wen_q, wen_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [31:0]      busy_q, busy_d;
  logic             sb_fault_q, sb_fault_d;

  logic             grant_vld;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] cand;
  logic [NREQ-1:0]  grant_oh;
  logic [4:0]       g_addr;
  logic [XLEN-1:0]  g_data;
  logic             wr_active;
  logic [31:0]      set_vec, clr_vec;
  logic             waw_fault, stray_fault;

  // Round-robin search starting at rr_ptr_q, wrapping modulo NREQ.
  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % NREQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (rst) grant_vld = 1'b0;

    grant_oh = '0;
    if (grant_vld) grant_oh[grant_idx] = 1'b1;

    g_addr = '0;
    g_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_oh[i]) begin
        g_addr = req_addr[5*i +: 5];
        g_data = req_data[XLEN*i +: XLEN];
      end
    end
  end

  assign req_ready = grant_oh;

  // A write whose port cycle lands in reset is dropped, and must not touch the scoreboard.
  assign wr_active = wen_q & ~rst;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) rr_ptr_d = (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    // x0 beats are consumed but never reach the register file.
    wen_d   = grant_vld && (g_addr != 5'd0);
    waddr_d = grant_vld ? g_addr : waddr_q;
    wdata_d = grant_vld ? g_data : wdata_q;

    set_vec = '0;
    if (iss_valid && (iss_rd != 5'd0)) set_vec[iss_rd] = 1'b1;
    clr_vec = '0;
    if (wr_active) clr_vec[waddr_q] = 1'b1;

    // Set is OR-ed after the clear so a new producer wins a same-cycle collision.
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;

    waw_fault   = (set_vec != '0) && busy_q[iss_rd] && !clr_vec[iss_rd];
    stray_fault = wr_active && !busy_q[waddr_q];
    sb_fault_d  = sb_fault_q | waw_fault | stray_fault;
  end

  // NOTE: the busy array is 32 plain flops, not a RAM, so it is cleared by reset like the rest of the state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      rr_ptr_q   <= '0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= '0;
      sb_fault_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      sb_fault_q <= sb_fault_d;
    end
  end

  assign wen_out   = wr_active;
  assign waddr_out = waddr_q;
  assign wdata_out = wdata_q;
  assign rs1_busy  = busy_q[iss_rs1];
  assign rs2_busy  = busy_q[iss_rs2];
  assign rd_busy   = busy_q[iss_rd];
  assign sb_fault  = sb_fault_q;

endmodule

// File: tb/tb_int_rf_wb_arbiter.sv
// Directed bench for int_rf_wb_arbiter: inputs change 1 unit after posedge,
// outputs are compared at negedge against hand-computed values.
module tb_int_rf_wb_arbiter;

  localparam int XLEN = 64;
  localparam int NREQ = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [5*NREQ-1:0]    req_addr;
  logic [XLEN*NREQ-1:0] req_data;
  logic                 wen_out;
  logic [4:0]           waddr_out;
  logic [XLEN-1:0]      wdata_out;
  logic                 iss_valid;
  logic [4:0]           iss_rd, iss_rs1, iss_rs2;
  logic                 rs1_busy, rs2_busy, rd_busy, sb_fault;

  int tests_run    = 0;
  int tests_failed = 0;

  int_rf_wb_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .wen_out(wen_out), .waddr_out(waddr_out), .wdata_out(wdata_out),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .sb_fault(sb_fault)
  );

  always #50 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    iss_rs1   = '0;
    iss_rs2   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] seen;
    rst       = 1'b1;
    idle_inputs();
    req_valid = 3'b111;
    req_addr  = {5'd7, 5'd6, 5'd5};
    cyc();
    cyc();
    @(negedge clk);
    tests_run++;
    if (req_ready !== 3'b000) begin tests_failed++; $display("FAIL reset_ready: got %b want 000", req_ready); end
    tests_run++;
    if (wen_out !== 1'b0 || waddr_out !== 5'd0 || wdata_out !== 64'd0) begin
      tests_failed++; $display("FAIL reset_wport: got wen=%b addr=%0d data=%h want 0/0/0", wen_out, waddr_out, wdata_out);
    end
    tests_run++;
    if (sb_fault !== 1'b0) begin tests_failed++; $display("FAIL reset_fault: got %b want 0", sb_fault); end
    seen = '0;
    for (int r = 0; r < 32; r++) begin
      iss_rs1 = 5'(r);
      #1;
      seen[r] = rs1_busy;
    end
    tests_run++;
    if (seen !== 32'd0) begin tests_failed++; $display("FAIL reset_busy: got %h want 00000000", seen); end
    cyc();
    rst     = 1'b0;
    iss_rs1 = '0;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 3'b001) begin tests_failed++; $display("FAIL reset_first_grant: got %b want 001", req_ready); end
    cyc();
    idle_inputs();
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_rdy;
    do_reset();
    req_valid = 3'b111;
    req_addr  = {5'd7, 5'd6, 5'd5};
    req_data  = {64'd102, 64'd101, 64'd100};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_rdy = 3'b001 << (k % 3);
      tests_run++;
      if (req_ready !== exp_rdy) begin tests_failed++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_rdy); end
      if (k > 0) begin
        tests_run++;
        if (wen_out !== 1'b1 || waddr_out !== 5'(5 + (k - 1) % 3)) begin
          tests_failed++; $display("FAIL rr_write[%0d]: got wen=%b addr=%0d want 1/%0d", k, wen_out, waddr_out, 5 + (k - 1) % 3);
        end
      end
      cyc();
    end
    req_valid = '0;
    @(negedge clk);
    tests_run++;
    if (wen_out !== 1'b1 || waddr_out !== 5'd7 || wdata_out !== 64'd102) begin
      tests_failed++; $display("FAIL rr_last_write: got wen=%b addr=%0d data=%0d want 1/7/102", wen_out, waddr_out, wdata_out);
    end
    cyc();
    @(negedge clk);
    tests_run++;
    if (wen_out !== 1'b0) begin tests_failed++; $display("FAIL rr_drain: got wen=%b want 0", wen_out); end
  endtask

  task automatic test_latency();
    do_reset();
    req_valid = 3'b010;
    req_addr  = {5'd0, 5'd12, 5'd0};
    req_data  = {64'd0, 64'hDEAD_BEEF_0000_0001, 64'd0};
    @(negedge clk);
    tests_run++;
    if (req_ready !== 3'b010 || wen_out !== 1'b0) begin
      tests_failed++; $display("FAIL lat_grant: got ready=%b wen=%b want 010/0", req_ready, wen_out);
    end
    cyc();
    req_valid = '0;
    @(negedge clk);
    tests_run++;
    if (wen_out !== 1'b1 || waddr_out !== 5'd12 || wdata_out !== 64'hDEAD_BEEF_0000_0001) begin
      tests_failed++; $display("FAIL lat_write: got wen=%b addr=%0d data=%h want 1/12/deadbeef00000001", wen_out, waddr_out, wdata_out);
    end
    cyc();
    @(negedge clk);
    tests_run++;
    if (wen_out !== 1'b0 || waddr_out !== 5'd12 || wdata_out !== 64'hDEAD_BEEF_0000_0001) begin
      tests_failed++; $display("FAIL lat_hold: got wen=%b addr=%0d data=%h want 0/12/deadbeef00000001", wen_out, waddr_out, wdata_out);
    end
  endtask

  task automatic test_scoreboard();
    do_reset();
    iss_valid = 1'b1;
    iss_rd    = 5'd9;
    @(negedge clk);
    tests_run++;
    if (rd_busy !== 1'b0) begin tests_failed++; $display("FAIL sb_pre_issue: got rd_busy=%b want 0", rd_busy); end
    cyc();
    iss_valid = 1'b0;
    iss_rs1   = 5'd9;
    @(negedge clk);
    tests_run++;
    if (rs1_busy !== 1'b1) begin tests_failed++; $display("FAIL sb_after_issue: got rs1_busy=%b want 1", rs1_busy); end
    cyc();
    req_valid = 3'b001;
    req_addr  = {5'd0, 5'd0, 5'd9};
    req_data  = {64'd0, 64'd0, 64'h99};
    @(negedge clk);
    tests_run++;
    if (rs1_busy !== 1'b1 || req_ready !== 3'b001) begin
      tests_failed++; $display("FAIL sb_grant: got rs1_busy=%b ready=%b want 1/001", rs1_busy, req_ready);
    end
    cyc();
    req_valid = '0;
    @(negedge clk);
    tests_run++;
    if (wen_out !== 1'b1 || waddr_out !== 5'd9 || rs1_busy !== 1'b1) begin
      tests_failed++; $display("FAIL sb_wcycle: got wen=%b addr=%0d rs1_busy=%b want 1/9/1", wen_out, waddr_out, rs1_busy);
    end
    cyc();
    @(negedge clk);
    tests_run++;
    if (rs1_busy !== 1'b0 || sb_fault !== 1'b0) begin
      tests_failed++; $display("FAIL sb_cleared: got rs1_busy=%b fault=%b want 0/0", rs1_busy, sb_fault);
    end
  endtask

  task automatic test_collision();
    do_reset();
    iss_valid = 1'b1;
    iss_rd    = 5'd4;
    cyc();
    iss_valid = 1'b0;
    req_valid = 3'b001;
    req_addr  = {5'd0, 5'd0, 5'd4};
    req_data  = {64'd0, 64'd0, 64'h44};
    cyc();
    req_valid = '0;
    iss_valid = 1'b1;
    iss_rd    = 5'd4;
    @(negedge clk);
    tests_run++;
    if (wen_out !== 1'b1 || waddr_out !== 5'd4) begin
      tests_failed++; $display("FAIL col_write: got wen=%b addr=%0d want 1/4", wen_out, waddr_out);
    end
    cyc();
    iss_valid = 1'b0;
    iss_rs2   = 5'd4;
    @(negedge clk);
    tests_run++;
    if (rs2_busy !== 1'b1 || sb_fault !== 1'b0) begin
      tests_failed++; $display("FAIL col_set_wins: got rs2_busy=%b fault=%b want 1/0", rs2_busy, sb_fault);
    end
    cyc();
    iss_valid = 1'b1;
    iss_rd    = 5'd4;
    @(negedge clk);
    tests_run++;
    if (rd_busy !== 1'b1) begin tests_failed++; $display("FAIL col_rd_busy: got %b want 1", rd_busy); end
    cyc();
    iss_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (sb_fault !== 1'b1) begin tests_failed++; $display("FAIL col_waw_fault: got %b want 1", sb_fault); end
    cyc();
    cyc();
    @(negedge clk);
    tests_run++;
    if (sb_fault !== 1'b1) begin tests_failed++; $display("FAIL col_sticky: got %b want 1", sb_fault); end
  endtask

  task automatic test_x0_stray();
    do_reset();
    req_valid = 3'b100;
    req_addr  = {5'd0, 5'd0, 5'd0};
    req_data  = {64'h1234, 64'd0, 64'd0};
    iss_rd    = 5'd0;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 3'b100 || rd_busy !== 1'b0) begin
      tests_failed++; $display("FAIL x0_accept: got ready=%b rd_busy=%b want 100/0", req_ready, rd_busy);
    end
    cyc();
    req_valid = 3'b111;
    req_addr  = {5'd0, 5'd0, 5'd20};
    req_data  = {64'd0, 64'd0, 64'h2020};
    @(negedge clk);
    tests_run++;
    if (wen_out !== 1'b0 || sb_fault !== 1'b0 || req_ready !== 3'b001) begin
      tests_failed++; $display("FAIL x0_nowrite: got wen=%b fault=%b ready=%b want 0/0/001", wen_out, sb_fault, req_ready);
    end
    cyc();
    req_valid = '0;
    @(negedge clk);
    tests_run++;
    if (wen_out !== 1'b1 || waddr_out !== 5'd20 || wdata_out !== 64'h2020) begin
      tests_failed++; $display("FAIL stray_write: got wen=%b addr=%0d data=%h want 1/20/2020", wen_out, waddr_out, wdata_out);
    end
    cyc();
    @(negedge clk);
    tests_run++;
    if (sb_fault !== 1'b1) begin tests_failed++; $display("FAIL stray_fault: got %b want 1", sb_fault); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 3'b001;
    req_addr  = {5'd0, 5'd0, 5'd3};
    req_data  = {64'd0, 64'd0, 64'h33};
    cyc();
    rst       = 1'b1;
    req_valid = 3'b111;
    @(negedge clk);
    tests_run++;
    if (wen_out !== 1'b0 || req_ready !== 3'b000) begin
      tests_failed++; $display("FAIL mid_reset_drop: got wen=%b ready=%b want 0/000", wen_out, req_ready);
    end
    cyc();
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);
    tests_run++;
    if (wen_out !== 1'b0 || sb_fault !== 1'b0) begin
      tests_failed++; $display("FAIL mid_reset_after: got wen=%b fault=%b want 0/0", wen_out, sb_fault);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_latency();
    test_scoreboard();
    test_collision();
    test_x0_stray();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/int_rf_wb_arbiter.md
Name: int_rf_wb_arbiter

Overview:
- Write-back arbiter and scoreboard for the integer register file's single write port.
- Shares the port between NREQ execution units (index 0 ALU, 1 LSU, 2 MDU) with round-robin arbitration and valid/ready handshakes.
- Registers the winning write toward the register file.
- Keeps a 32-entry busy scoreboard so issue logic can detect RAW/WAW hazards against in-flight writes.

Parameters:
- XLEN, 64, data width of register file entries.
- NREQ, 3, number of write-back requesters (2..8).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  requester i holds a write-back.
- req_ready  out  NREQ  grant; the beat transfers when req_valid[i] and req_ready[i] are both high.
- req_addr  in  5*NREQ  destination register of requester i, at bits [5i+4:5i].
- req_data  in  XLEN*NREQ  write data of requester i, at bits [XLEN*i+XLEN-1:XLEN*i].
- wen_out  out  1  register file write enable.
- waddr_out  out  5  register file write address.
- wdata_out  out  XLEN  register file write data.
- iss_valid  in  1  issue stage allocates a destination this cycle.
- iss_rd  in  5  destination register being allocated.
- iss_rs1  in  5  source 1 of the instruction at issue.
- iss_rs2  in  5  source 2 of the instruction at issue.
- rs1_busy  out  1  iss_rs1 has a pending write (combinational).
- rs2_busy  out  1  iss_rs2 has a pending write (combinational).
- rd_busy  out  1  iss_rd has a pending write (combinational, WAW check).
- sb_fault  out  1  sticky error flag.

Behaviour:
- Reset: when rst=1 at a posedge:
  - wen_out=0, waddr_out=0, wdata_out=0.
  - all busy bits 0; rr_ptr=0; sb_fault=0.
  - req_ready is all-zero during any cycle where rst=1.
- Arbitration (combinational, single cycle):
  - Search req_valid starting at index rr_ptr, wrapping modulo NREQ.
  - The first valid index g gets req_ready[g]=1; all other ready bits are 0.
  - At most one grant per cycle. No valid requests means no grant.
  - req_ready never asserts without the matching req_valid.
- Pointer update: on a grant, rr_ptr <= (g+1) mod NREQ. With no grant, rr_ptr holds.
- Write port (registered, latency 1):
  - On a grant at edge N, wen_out=1 with waddr_out/wdata_out = the granted beat during cycle N+1.
  - With no grant, wen_out=0 and waddr_out/wdata_out hold their previous values.
  - Sustained throughput is 1 write per cycle.
- x0 handling:
  - A beat with req_addr=0 is accepted (ready asserted, pointer advances) but produces wen_out=0.
  - x0 is never marked busy.
  - rs1_busy/rs2_busy/rd_busy are 0 for address 0.
- Scoreboard:
  - busy[r] is set at the edge where iss_valid=1 and iss_rd=r, r≠0.
  - busy[r] is cleared at the edge where wen_out=1 and waddr_out=r, i.e. the same edge the register file captures the data.
  - rsX_busy = busy[iss_rsX]. No forwarding: the cycle after the clear, busy reads 0.
- Simultaneous events:
  - If set and clear hit the same r in one cycle, the set wins and busy[r] stays 1 (new producer).
  - Sets and clears to different registers both take effect.
- Fault:
  - sb_fault <= 1 when iss_valid=1 with iss_rd≠0 and busy[iss_rd]=1 and no clear of iss_rd that cycle.
  - sb_fault <= 1 when wen_out=1 targets a register whose busy bit is 0.
  - sb_fault stays set until rst. Writes still proceed normally after a fault.
- Reset mid-operation:
  - A granted beat whose write-port cycle coincides with rst is discarded (wen_out forced 0).
  - Requesters must re-present after reset.
- Requesters must hold req_valid, addr and data stable until ready. The arbiter does not check this.

Test Plan:
- Reset:
  - Stimulus: hold rst=1 for 2 cycles with req_valid=3'b111.
  - Required: req_ready=0, wen_out=0, all busy=0, sb_fault=0; the first grant after release goes to index 0.
- Round-robin fairness:
  - Stimulus: req_valid=3'b111 held for 6 cycles, addrs 5/6/7.
  - Required: grant order 0,1,2,0,1,2; wen_out high for cycles 2–7 with waddr 5,6,7,5,6,7.
- Latency/data:
  - Stimulus: LSU alone writes x12=64'hDEAD_BEEF_0000_0001 at cycle N.
  - Required: wen_out=1, waddr_out=12, wdata_out matches in cycle N+1; wen_out=0 in N+2.
- Scoreboard lifecycle:
  - Stimulus: issue rd=9; next cycle query rs1=9; then ALU writes x9.
  - Required: rs1_busy=1 until the edge of the wen_out cycle for x9, then 0 the following cycle; sb_fault stays 0.
- Set/clear collision:
  - Stimulus: wen_out for x4 in the same cycle as iss_valid with rd=4.
  - Required: busy[4] remains 1, sb_fault=0.
  - Stimulus: a second iss_rd=4 with no write-back.
  - Required: sb_fault=1.
- x0 and stray write:
  - Stimulus: MDU writes x0.
  - Required: ready=1, wen_out=0, rd_busy for 0 is 0.
  - Stimulus: ALU writes x20 with busy[20]=0.
  - Required: the write occurs and sb_fault=1.
